// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU/ALUCtrl pair between two valid/ready requesters; 3 cycles per op (accept, EXEC, RESP).
// rsp_ready low parks the block in RESP with every output frozen; no new request is accepted until the response drains.
module alu_arbiter #(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DWIDTH-1:0] req_a0,
  input  logic [DWIDTH-1:0] req_b0,
  input  logic [DWIDTH-1:0] req_a1,
  input  logic [DWIDTH-1:0] req_b1,
  input  logic [3:0]        req_func0,
  input  logic [3:0]        req_func1,
  input  logic [1:0]        req_alu_op0,
  input  logic [1:0]        req_alu_op1,
  output logic [DWIDTH-1:0] alu_a,
  output logic [DWIDTH-1:0] alu_b,
  output logic [3:0]        alu_func,
  output logic [1:0]        alu_op,
  input  logic [DWIDTH-1:0] alu_out,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic [3:0]        func;
    logic [1:0]        op;
  } alu_cmd_t;

  state_t   state, state_nxt;
  logic     g;
  logic     last;
  logic     grant;
  logic     grant_vld;
  logic     accept;
  logic     rsp_hs;
  alu_cmd_t cmd_sel;
  alu_cmd_t cmd_q;

  // Round-robin: a lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 1'b0;
    case (req_valid)
      2'b01: begin grant_vld = 1'b1; grant = 1'b0;  end
      2'b10: begin grant_vld = 1'b1; grant = 1'b1;  end
      2'b11: begin grant_vld = 1'b1; grant = ~last; end
      default: begin grant_vld = 1'b0; grant = 1'b0; end
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && grant_vld) req_ready[grant] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    if (grant) cmd_sel = '{a: req_a1, b: req_b1, func: req_func1, op: req_alu_op1};
    else       cmd_sel = '{a: req_a0, b: req_b0, func: req_func0, op: req_alu_op0};
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state == RESP) rsp_valid[g] = 1'b1;
  end

  assign rsp_hs = |(rsp_valid & rsp_ready);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are only loaded on accept, so they stay frozen through EXEC and RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      g        <= 1'b0;
      last     <= 1'b1;
      cmd_q    <= '0;
      rsp_data <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        g     <= grant;
        last  <= grant;
        cmd_q <= cmd_sel;
      end
      if (state == EXEC) rsp_data <= alu_out;
      if (rsp_hs) op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign alu_a    = cmd_q.a;
  assign alu_b    = cmd_q.b;
  assign alu_func = cmd_q.func;
  assign alu_op   = cmd_q.op;

endmodule
